// File: rtl/ex_pkg.sv
// Shared constants for the EX/MEM stage: word width, ALU classes, funct codes, multiplier FSM states.
package ex_pkg;
  localparam int WORD_W = 32;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_MULT = 6'h18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } mul_state_t;
endpackage

// File: rtl/ex_mem_stage_if.sv
// ID/EX operand and control bundle in, registered EX/MEM bundle and upstream stall out.
interface ex_mem_stage_if;
  logic        in_valid;
  logic        flush;
  logic [31:0] nextpc;
  logic [31:0] reg_file_out_data1;
  logic [31:0] reg_file_out_data2;
  logic [31:0] sgn_ext_imm_out;
  logic        reg_write;
  logic        mem_to_reg;
  logic        mem_write;
  logic        mem_read;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic [4:0]  wr_reg;
  logic        stall_out;
  logic        ex_valid;
  logic        ex_reg_write;
  logic        ex_mem_to_reg;
  logic        ex_mem_write;
  logic        ex_mem_read;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_write_data;
  logic [31:0] ex_branch_target;
  logic        ex_zero;
  logic [4:0]  ex_wr_reg;

  modport master (
    output in_valid, flush, nextpc, reg_file_out_data1, reg_file_out_data2, sgn_ext_imm_out,
           reg_write, mem_to_reg, mem_write, mem_read, alu_src, alu_op, wr_reg,
    input  stall_out, ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_mem_read,
           ex_alu_result, ex_write_data, ex_branch_target, ex_zero, ex_wr_reg
  );

  modport slave (
    input  in_valid, flush, nextpc, reg_file_out_data1, reg_file_out_data2, sgn_ext_imm_out,
           reg_write, mem_to_reg, mem_write, mem_read, alu_src, alu_op, wr_reg,
    output stall_out, ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_mem_read,
           ex_alu_result, ex_write_data, ex_branch_target, ex_zero, ex_wr_reg
  );
endinterface

// File: rtl/ex_mem_stage_mul.sv
// seq_mul: 32-step shift-add multiplier keeping the low 32 bits; start is honoured only in IDLE.
// abort (flush) drops any operation in flight back to IDLE without producing a result.
module seq_mul (
  input  logic        clk,
  input  logic        reset,
  input  logic        abort,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);
  import ex_pkg::*;

  mul_state_t        state;
  logic [WORD_W-1:0] mcand;
  logic [WORD_W-1:0] mplier;
  logic [WORD_W-1:0] acc;
  logic [4:0]        count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state  <= ST_BUSY;
          mcand  <= a;
          mplier <= b;
          acc    <= '0;
          count  <= '0;
        end
        ST_BUSY: begin
          // Bits shifted past bit 31 of mcand cannot reach the kept low word.
          acc    <= acc + (mplier[0] ? mcand : '0);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 5'd1;
          if (count == 5'd31) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (state == ST_BUSY);
  assign done    = (state == ST_DONE);
  assign product = acc;
endmodule

// File: rtl/ex_mem_stage.sv
// EX stage: ALU, branch target and EX/MEM register; 1-cycle latency, multiply (EX_MUL_EN) takes 34 edges.
// Stalls upstream through stall_out while a multiply is in flight; bubbles on flush, !in_valid or stall.
module ex_mem_stage (
  input logic           clk,
  input logic           reset,
  ex_mem_stage_if.slave bus
);
  import ex_pkg::*;

  logic [WORD_W-1:0] op_a, op_b, alu_res, result;
  logic [5:0]        funct;
  logic              stall;
  logic              valid_next;
  logic              mul_done;
  logic [WORD_W-1:0] mul_product;

  assign op_a  = bus.reg_file_out_data1;
  assign op_b  = bus.alu_src ? bus.sgn_ext_imm_out : bus.reg_file_out_data2;
  assign funct = bus.sgn_ext_imm_out[5:0];

  always_comb begin
    alu_res = op_a + op_b;
    case (bus.alu_op)
      ALU_SUB: alu_res = op_a - op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_RTYPE: begin
        case (funct)
          FN_SUB:  alu_res = op_a - op_b;
          FN_AND:  alu_res = op_a & op_b;
          FN_OR:   alu_res = op_a | op_b;
          FN_SLT:  alu_res = {{(WORD_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
          default: alu_res = op_a + op_b;
        endcase
      end
      default: alu_res = op_a + op_b;
    endcase
  end

`ifdef EX_MUL_EN
  logic is_mult;
  logic mul_busy;

  assign is_mult = (bus.alu_op == ALU_RTYPE) && (funct == FN_MULT);
  assign stall   = bus.in_valid & is_mult & ~mul_done & ~bus.flush;

  seq_mul u_mul (
    .clk     (clk),
    .reset   (reset),
    .abort   (bus.flush),
    .start   (bus.in_valid & is_mult & ~bus.flush & ~mul_busy & ~mul_done),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign stall       = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  assign bus.stall_out = stall;
  // The DONE cycle retires the multiply even though it is the edge the upstream advances on.
  assign valid_next = ~bus.flush & (mul_done | (bus.in_valid & ~stall));
  assign result     = mul_done ? mul_product : alu_res;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ex_valid         <= 1'b0;
      bus.ex_reg_write     <= 1'b0;
      bus.ex_mem_to_reg    <= 1'b0;
      bus.ex_mem_write     <= 1'b0;
      bus.ex_mem_read      <= 1'b0;
      bus.ex_alu_result    <= '0;
      bus.ex_write_data    <= '0;
      bus.ex_branch_target <= '0;
      bus.ex_zero          <= 1'b0;
      bus.ex_wr_reg        <= '0;
    end else begin
      bus.ex_valid         <= valid_next;
      bus.ex_reg_write     <= valid_next & bus.reg_write;
      bus.ex_mem_to_reg    <= valid_next & bus.mem_to_reg;
      bus.ex_mem_write     <= valid_next & bus.mem_write;
      bus.ex_mem_read      <= valid_next & bus.mem_read;
      bus.ex_alu_result    <= result;
      bus.ex_write_data    <= bus.reg_file_out_data2;
      bus.ex_branch_target <= bus.nextpc + {bus.sgn_ext_imm_out[WORD_W-3:0], 2'b00};
      bus.ex_zero          <= (result == '0);
      bus.ex_wr_reg        <= bus.wr_reg;
    end
  end
endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed table-driven bench for ex_mem_stage; multiply sequences are built only with EX_MUL_EN.
module tb_ex_mem_stage;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  ex_mem_stage_if bus ();
  ex_mem_stage dut (.clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct {
    logic        in_valid, flush, alu_src;
    logic [1:0]  alu_op;
    logic [3:0]  ctl;
    logic [31:0] nextpc, d1, d2, imm;
    logic [4:0]  wr;
    logic        exp_valid;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic [31:0] exp_bt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic iv, input logic fl, input logic src, input logic [1:0] op,
                         input logic [3:0] ctl, input logic [31:0] pc, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] imm, input logic [4:0] wr,
                         input logic ev, input logic [31:0] er, input logic ez, input logic [31:0] eb);
    vec_t v;
    v.in_valid = iv; v.flush = fl; v.alu_src = src; v.alu_op = op; v.ctl = ctl;
    v.nextpc = pc; v.d1 = d1; v.d2 = d2; v.imm = imm; v.wr = wr;
    v.exp_valid = ev; v.exp_res = er; v.exp_zero = ez; v.exp_bt = eb;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid = v.in_valid;  bus.flush = v.flush;  bus.alu_src = v.alu_src;
    bus.alu_op = v.alu_op;      bus.nextpc = v.nextpc;
    bus.reg_file_out_data1 = v.d1; bus.reg_file_out_data2 = v.d2;
    bus.sgn_ext_imm_out = v.imm;   bus.wr_reg = v.wr;
    {bus.reg_write, bus.mem_to_reg, bus.mem_write, bus.mem_read} = v.ctl;
  endtask

  task automatic drive_op(input logic iv, input logic fl, input logic [1:0] op,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
    vec_t v;
    v.in_valid = iv; v.flush = fl; v.alu_src = 1'b0; v.alu_op = op; v.ctl = 4'b1000;
    v.nextpc = 32'h0; v.d1 = d1; v.d2 = d2; v.imm = imm; v.wr = 5'd9;
    drive(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs_or();
    return {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_to_reg, bus.ex_mem_write, bus.ex_mem_read,
            bus.ex_zero, bus.stall_out} | bus.ex_alu_result | bus.ex_write_data |
           bus.ex_branch_target | {27'b0, bus.ex_wr_reg};
  endfunction

  initial begin
    vec_t v;
    // Table: valid, flush, alu_src, alu_op, ctl, nextpc, d1, d2, imm, wr | valid, result, zero, target
    add_vec(1,0,0,2'b10,4'b1000,32'h0,     32'hFFFFFFFF,32'h1,       32'h2A,      5'd3, 1,32'h1,       0,32'hA8);
    add_vec(1,0,0,2'b01,4'b0001,32'h100,   32'h1234,    32'h1234,    32'h3,       5'd7, 1,32'h0,       1,32'h10C);
    add_vec(1,0,1,2'b00,4'b1100,32'h200,   32'h7FFFFFFF,32'h55,      32'h1,       5'd31,1,32'h80000000,0,32'h204);
    add_vec(1,0,0,2'b11,4'b0010,32'h40,    32'hF0F00000,32'h00000F0F,32'h0,       5'd1, 1,32'hF0F00F0F,0,32'h40);
    add_vec(1,0,0,2'b10,4'b1000,32'h0,     32'hFF00FF00,32'h0FF00FF0,32'h24,      5'd2, 1,32'h0F000F00,0,32'h90);
    add_vec(1,0,0,2'b10,4'b1010,32'h0,     32'h1,       32'h2,       32'h25,      5'd4, 1,32'h3,       0,32'h94);
    add_vec(1,0,0,2'b10,4'b1000,32'h0,     32'hFFFFFFFF,32'h1,       32'h20,      5'd5, 1,32'h0,       1,32'h80);
    add_vec(1,0,0,2'b10,4'b1000,32'h0,     32'h0,       32'h1,       32'h22,      5'd6, 1,32'hFFFFFFFF,0,32'h88);
    add_vec(1,0,0,2'b10,4'b1000,32'h0,     32'h5,       32'hFFFFFFFD,32'h2A,      5'd8, 1,32'h0,       1,32'hA8);
    add_vec(1,0,0,2'b10,4'b0100,32'h0,     32'h2,       32'h3,       32'h3F,      5'd10,1,32'h5,       0,32'hFC);
`ifndef EX_MUL_EN
    add_vec(1,0,0,2'b10,4'b1000,32'h0,     32'h10000,   32'h10001,   32'h18,      5'd11,1,32'h20001,   0,32'h60);
`endif
    add_vec(1,1,0,2'b00,4'b1111,32'h0,     32'h1,       32'h1,       32'h0,       5'd12,0,32'h0,       0,32'h0);
    add_vec(0,0,0,2'b00,4'b1111,32'h0,     32'h1,       32'h1,       32'h0,       5'd13,0,32'h0,       0,32'h0);
    add_vec(1,0,1,2'b00,4'b1001,32'h1000,  32'h5,       32'h7,       32'hFFFFFFFF,5'd14,1,32'h4,       0,32'hFFC);
    add_vec(1,0,0,2'b00,4'b0110,32'h80000000,32'h10,    32'h20,      32'h40000001,5'd15,1,32'h30,      0,32'h80000004);
    add_vec(1,0,1,2'b00,4'b1000,32'h0,     32'h1,       32'h99,      32'h10,      5'd16,1,32'h11,      0,32'h40);
    add_vec(1,0,1,2'b01,4'b1000,32'h4,     32'h10,      32'h77,      32'h10,      5'd17,1,32'h0,       1,32'h44);

    // Reset with random inputs (non-mult funct so stall_out is defined to be 0).
    reset = 1'b1;
    v.in_valid = 1'b1; v.flush = 1'($urandom); v.alu_src = 1'($urandom); v.alu_op = 2'($urandom);
    v.ctl = 4'($urandom); v.nextpc = $urandom; v.d1 = $urandom; v.d2 = $urandom;
    v.imm = {$urandom} & 32'hFFFFFFC0 | 32'h20; v.wr = 5'($urandom);
    drive(v);
    tick();
    tick();
    chk("reset_outputs", outs_or(), 32'h0);
    chk("reset_stall", {31'b0, bus.stall_out}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_stall", i), {31'b0, bus.stall_out}, 32'h0);
      tick();
      chk($sformatf("v%0d_valid", i), {31'b0, bus.ex_valid}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("v%0d_ctl", i),
          {28'b0, bus.ex_reg_write, bus.ex_mem_to_reg, bus.ex_mem_write, bus.ex_mem_read},
          vecs[i].exp_valid ? {28'b0, vecs[i].ctl} : 32'h0);
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_result", i), bus.ex_alu_result, vecs[i].exp_res);
        chk($sformatf("v%0d_zero", i), {31'b0, bus.ex_zero}, {31'b0, vecs[i].exp_zero});
        chk($sformatf("v%0d_target", i), bus.ex_branch_target, vecs[i].exp_bt);
        chk($sformatf("v%0d_wdata", i), bus.ex_write_data, vecs[i].d2);
        chk($sformatf("v%0d_wr_reg", i), {27'b0, bus.ex_wr_reg}, {27'b0, vecs[i].wr});
      end
    end

    // Reset wins over a simultaneous flush, starting from a loaded register.
    drive_op(1, 0, 2'b00, 32'h3, 32'h4, 32'h100);
    tick();
    chk("preload_valid", {31'b0, bus.ex_valid}, 32'h1);
    reset = 1'b1;
    drive_op(1, 1, 2'b00, 32'h3, 32'h4, 32'h100);
    tick();
    chk("reset_flush_outputs", outs_or(), 32'h0);
    reset = 1'b0;
    drive_op(0, 0, 2'b00, 32'h0, 32'h0, 32'h0);

`ifdef EX_MUL_EN
    // Held multiply: 33 stalled edges, result on edge 34.
    drive_op(1, 0, 2'b10, 32'h10000, 32'h10001, 32'h18);
    for (int e = 1; e <= 34; e++) begin
      #1;
      chk($sformatf("mul_stall_e%0d", e), {31'b0, bus.stall_out}, {31'b0, (e <= 33)});
      tick();
      chk($sformatf("mul_valid_e%0d", e), {31'b0, bus.ex_valid}, {31'b0, (e == 34)});
    end
    chk("mul_result", bus.ex_alu_result, 32'h00010000);
    chk("mul_zero", {31'b0, bus.ex_zero}, 32'h0);
    drive_op(0, 0, 2'b00, 32'h0, 32'h0, 32'h0);
    tick();

    // Flush at BUSY count 10 aborts; a following add completes in one cycle.
    drive_op(1, 0, 2'b10, 32'h7, 32'h9, 32'h18);
    repeat (11) tick();
    chk("busy_stall", {31'b0, bus.stall_out}, 32'h1);
    drive_op(1, 1, 2'b10, 32'h7, 32'h9, 32'h18);
    #1;
    chk("flush_stall", {31'b0, bus.stall_out}, 32'h0);
    tick();
    chk("flush_valid", {31'b0, bus.ex_valid}, 32'h0);
    drive_op(1, 0, 2'b00, 32'h21, 32'h21, 32'h0);
    #1;
    chk("post_flush_stall", {31'b0, bus.stall_out}, 32'h0);
    tick();
    chk("post_flush_valid", {31'b0, bus.ex_valid}, 32'h1);
    chk("post_flush_result", bus.ex_alu_result, 32'h42);

    // Reset mid-multiply: product must never be written.
    drive_op(1, 0, 2'b10, 32'h3, 32'h5, 32'h18);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mul_reset_outputs", outs_or() & 32'hFFFFFFFE, 32'h0);
    drive_op(0, 0, 2'b00, 32'h0, 32'h0, 32'h0);
    for (int e = 0; e < 35; e++) begin
      tick();
      chk($sformatf("mul_reset_idle_e%0d", e), {31'b0, bus.ex_valid}, 32'h0);
    end
`else
    drive_op(1, 0, 2'b10, 32'h10000, 32'h10001, 32'h18);
    #1;
    chk("nomul_stall", {31'b0, bus.stall_out}, 32'h0);
    tick();
    chk("nomul_result", bus.ex_alu_result, 32'h20001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
